// File: rtl/kbd_pkg.sv
// kbd_pkg: shared types and constants for the PS/2 keyboard event path.
//   kbd_event_t   - packed event word, same layout as ev_data
//   parse_state_e - scancode prefix parser states
//   SC_*          - scancode set 2 bytes of interest
//   is_discard()  - true for protocol/status bytes that never become events
package kbd_pkg;

    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       caps;
        logic       alt;
        logic       ctrl;
        logic       shift;
        logic [1:0] rsvd;
        logic [7:0] code;
    } kbd_event_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_E0   = 2'd1,
        P_F0   = 2'd2,
        P_E0F0 = 2'd3
    } parse_state_e;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_E1     = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERRFF  = 8'hFF;

    // Pause-sequence lead-in and keyboard status replies are dropped at IDLE.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == SC_E1) || (b == SC_BAT_OK) || (b == SC_ACK) ||
               (b == SC_RESEND) || (b == SC_ECHO) || (b == SC_ERR0) ||
               (b == SC_ERRFF);
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
//   clk, rst            - system clock, async active-high reset
//   ps2_clk, ps2_data   - raw asynchronous PS/2 pins
//   byte_valid          - 1-cycle pulse, rx_byte holds a good frame's data
//   err                 - 1-cycle pulse on bad start/parity/stop or timeout
//   rx_byte             - last received data byte
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic       err,
    output logic [7:0] rx_byte
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q, err_d;
    logic                   fall;
    logic                   data_bit;

    // The synchronisers reset to 1 (idle bus level) so reset release cannot
    // look like a falling edge.
    assign fall     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_bit = data_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        timer_d      = timer_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        if (fall) begin
            timer_d = '0;
            if (bit_cnt_q == 4'd0) begin
                // A start bit of 1 is a framing error; stay waiting for a start.
                if (!data_bit) bit_cnt_d = 4'd1;
                else           err_d     = 1'b1;
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {data_bit, shift_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                parity_d  = data_bit;
                bit_cnt_d = 4'd10;
            end else begin
                // Stop bit: data plus parity must have odd weight.
                bit_cnt_d = 4'd0;
                if (data_bit && (^{shift_q, parity_q})) byte_valid_d = 1'b1;
                else                                   err_d        = 1'b1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = 4'd0;
                timer_d   = '0;
                err_d     = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= 8'd0;
            parity_q     <= 1'b0;
            timer_q      <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            timer_q      <= timer_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign err        = err_q;
    assign rx_byte    = shift_q;

endmodule

// File: rtl/kbd_event_fifo.sv
// kbd_event_fifo: PS/2 keyboard front-end producing tagged key events.
//   clk, rst          - system clock, async active-high reset
//   PS2Clk, PS2Data   - raw PS/2 pins
//   pop               - consumer removes head entry when ev_valid=1
//   clr_err           - clears ovf and frame_err
//   ev_valid, ev_data - show-ahead head of the event FIFO
//   count             - FIFO occupancy
//   shift/ctrl/alt/caps - live modifier state
//   ovf, frame_err    - sticky drop / receive-error flags
module kbd_event_fifo
    import kbd_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     PS2Clk,
    input  logic                     PS2Data,
    input  logic                     pop,
    input  logic                     clr_err,
    output logic                     ev_valid,
    output logic [15:0]              ev_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     shift,
    output logic                     ctrl,
    output logic                     alt,
    output logic                     caps,
    output logic                     ovf,
    output logic                     frame_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic       byte_valid, rx_err;
    logic [7:0] rx_byte;

    ps2_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (PS2Clk),
        .ps2_data   (PS2Data),
        .byte_valid (byte_valid),
        .err        (rx_err),
        .rx_byte    (rx_byte)
    );

    parse_state_e state_q, state_d;
    logic lshift_q, lshift_d, rshift_q, rshift_d;
    logic lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic lalt_q, lalt_d, ralt_q, ralt_d;
    logic caps_q, caps_d, caps_held_q, caps_held_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic ovf_q, ovf_d, frame_err_q, frame_err_d;
    logic emit, ev_brk, ev_ext;
    logic do_push, do_pop, full;
    kbd_event_t new_ev;
    kbd_event_t mem [DEPTH];

    // Prefix parser: E0/F0 bytes only set up the tag for the following byte.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_brk  = 1'b0;
        ev_ext  = 1'b0;
        if (byte_valid) begin
            unique case (state_q)
                P_IDLE: begin
                    if (rx_byte == SC_E0)        state_d = P_E0;
                    else if (rx_byte == SC_F0)   state_d = P_F0;
                    else if (!is_discard(rx_byte)) emit  = 1'b1;
                end
                P_E0: begin
                    if (rx_byte == SC_F0) begin
                        state_d = P_E0F0;
                    end else begin
                        emit    = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = P_IDLE;
                    end
                end
                P_F0: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    state_d = P_IDLE;
                end
                P_E0F0: begin
                    emit    = 1'b1;
                    ev_brk  = 1'b1;
                    ev_ext  = 1'b1;
                    state_d = P_IDLE;
                end
                default: state_d = P_IDLE;
            endcase
        end
    end

    // Held-key tracking; caps_held blocks typematic repeats from re-toggling.
    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        lalt_d      = lalt_q;
        ralt_d      = ralt_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (emit) begin
            if (!ev_ext) begin
                if (rx_byte == SC_LSHIFT) lshift_d = ~ev_brk;
                if (rx_byte == SC_RSHIFT) rshift_d = ~ev_brk;
                if (rx_byte == SC_CTRL)   lctrl_d  = ~ev_brk;
                if (rx_byte == SC_ALT)    lalt_d   = ~ev_brk;
                if (rx_byte == SC_CAPS) begin
                    if (!ev_brk) begin
                        if (!caps_held_q) caps_d = ~caps_q;
                        caps_held_d = 1'b1;
                    end else begin
                        caps_held_d = 1'b0;
                    end
                end
            end else begin
                if (rx_byte == SC_CTRL) rctrl_d = ~ev_brk;
                if (rx_byte == SC_ALT)  ralt_d  = ~ev_brk;
            end
        end
    end

    // Event word carries the modifier state after this event's own update.
    always_comb begin
        new_ev.brk   = ev_brk;
        new_ev.ext   = ev_ext;
        new_ev.caps  = caps_d;
        new_ev.alt   = lalt_d | ralt_d;
        new_ev.ctrl  = lctrl_d | rctrl_d;
        new_ev.shift = lshift_d | rshift_d;
        new_ev.rsvd  = 2'b00;
        new_ev.code  = rx_byte;
    end

    // FIFO control: a pop frees the slot a simultaneous push needs at full.
    always_comb begin
        do_pop   = pop & (count_q != '0);
        full     = (count_q == CW'(DEPTH));
        do_push  = emit & (~full | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
        ovf_d       = (emit & full & ~do_pop) | (ovf_q & ~clr_err);
        frame_err_d = rx_err | (frame_err_q & ~clr_err);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= P_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            lalt_q      <= 1'b0;
            ralt_q      <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            lalt_q      <= lalt_d;
            ralt_q      <= ralt_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Storage needs no reset: ev_data is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= new_ev;
    end

    assign ev_valid  = (count_q != '0);
    assign ev_data   = ev_valid ? mem[rd_ptr_q] : 16'h0000;
    assign count     = count_q;
    assign shift     = lshift_q | rshift_q;
    assign ctrl      = lctrl_q | rctrl_q;
    assign alt       = lalt_q | ralt_q;
    assign caps      = caps_q;
    assign ovf       = ovf_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_kbd_event_fifo.sv
// tb_kbd_event_fifo: drives PS/2 frames into kbd_event_fifo and compares
// every output against a prefix-flag / held-key / queue reference model.
module tb_kbd_event_fifo;

    localparam int DEPTH   = 8;
    localparam int SYNC    = 2;
    localparam int TIMEOUT = 100;
    localparam int HALF    = 10;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          PS2Clk = 1'b1;
    logic          PS2Data = 1'b1;
    logic          pop = 1'b0;
    logic          clr_err = 1'b0;
    logic          ev_valid;
    logic [15:0]   ev_data;
    logic [CW-1:0] count;
    logic          shift, ctrl, alt, caps, ovf, frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] mq[$];
    bit mExt, mBrk, mLs, mRs, mLc, mRc, mLa, mRa, mCaps, mCapsHeld, mOvf, mFerr;

    kbd_event_fifo #(
        .DEPTH       (DEPTH),
        .SYNC_STAGES (SYNC),
        .TIMEOUT_CYC (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .PS2Clk    (PS2Clk),
        .PS2Data   (PS2Data),
        .pop       (pop),
        .clr_err   (clr_err),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .count     (count),
        .shift     (shift),
        .ctrl      (ctrl),
        .alt       (alt),
        .caps      (caps),
        .ovf       (ovf),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic void modelReset();
        mq.delete();
        {mExt, mBrk, mLs, mRs, mLc, mRc, mLa, mRa} = '0;
        {mCaps, mCapsHeld, mOvf, mFerr} = '0;
    endfunction

    function automatic bit isDiscard(input logic [7:0] b);
        return b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    endfunction

    // Byte-level model: prefixes accumulate into flags, the next byte consumes them.
    function automatic void modelByte(input logic [7:0] b);
        logic [15:0] ev;
        bit mk;
        if (!mBrk && b == 8'hF0) begin mBrk = 1; return; end
        if (!mBrk && !mExt && b == 8'hE0) begin mExt = 1; return; end
        if (!mBrk && !mExt && isDiscard(b)) return;
        mk = !mBrk;
        if (!mExt) begin
            case (b)
                8'h12: mLs = mk;
                8'h59: mRs = mk;
                8'h14: mLc = mk;
                8'h11: mLa = mk;
                8'h58: begin
                    if (mk && !mCapsHeld) mCaps = !mCaps;
                    mCapsHeld = mk;
                end
                default: ;
            endcase
        end else begin
            if (b == 8'h14) mRc = mk;
            if (b == 8'h11) mRa = mk;
        end
        ev = {mBrk, mExt, mCaps, mLa | mRa, mLc | mRc, mLs | mRs, 2'b00, b};
        mExt = 0;
        mBrk = 0;
        if (mq.size() == DEPTH) mOvf = 1;
        else mq.push_back(ev);
    endfunction

    task automatic checkAll(input string tag);
        logic [15:0] head;
        head = (mq.size() != 0) ? mq[0] : 16'h0000;
        checkOutput({tag, "_valid"}, ev_valid, mq.size() != 0);
        checkOutput({tag, "_data"}, ev_data, head);
        checkOutput({tag, "_count"}, count, mq.size());
        checkOutput({tag, "_shift"}, shift, mLs | mRs);
        checkOutput({tag, "_ctrl"}, ctrl, mLc | mRc);
        checkOutput({tag, "_alt"}, alt, mLa | mRa);
        checkOutput({tag, "_caps"}, caps, mCaps);
        checkOutput({tag, "_ovf"}, ovf, mOvf);
        checkOutput({tag, "_ferr"}, frame_err, mFerr);
    endtask

    // Sends nbits of a frame (11 = complete). popAtPush raises pop exactly on
    // the FIFO write edge; checkLat verifies the write lands on that edge.
    task automatic applyStimulus(input logic [7:0] b, input bit badPar, input int nbits,
                                 input bit popAtPush, input bit checkLat);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ badPar, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            PS2Data = fr[i];
            repeat (HALF) @(negedge clk);
            PS2Clk = 1'b0;
            if (i == 10 && (popAtPush || checkLat)) begin
                repeat (SYNC + 1) @(posedge clk);
                #1;
                if (checkLat) checkOutput("latency_before", ev_valid, 0);
                if (popAtPush) pop = 1'b1;
                @(posedge clk);
                #1;
                pop = 1'b0;
                if (checkLat) checkOutput("latency_at", ev_valid, 1);
                repeat (HALF - SYNC - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            PS2Clk = 1'b1;
        end
        @(negedge clk);
        PS2Data = 1'b1;
        if (nbits < 11) begin
            repeat (TIMEOUT + 50) @(negedge clk);
            mFerr = 1;
        end else begin
            repeat (2 * HALF) @(negedge clk);
            if (badPar) mFerr = 1;
            else begin
                if (popAtPush && mq.size() != 0) void'(mq.pop_front());
                modelByte(b);
            end
        end
    endtask

    task automatic popOne();
        @(negedge clk);
        pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        @(negedge clk);
    endtask

    task automatic clearErr();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        mOvf = 0;
        mFerr = 0;
    endtask

    initial begin
        logic [7:0] pool [10];
        logic [7:0] b;
        pool = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58, 8'h1C, 8'hE0, 8'hF0, 8'hAA, 8'h23};
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", ev_valid, 0);
        checkOutput("reset_data", ev_data, 0);
        checkOutput("reset_count", count, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkAll("idle");

        // Make/break of a plain key, with exact write latency on the first.
        applyStimulus(8'h1C, 0, 11, 0, 1);
        checkOutput("make_1c", ev_data, 16'h001C);
        applyStimulus(8'hF0, 0, 11, 0, 0);
        applyStimulus(8'h1C, 0, 11, 0, 0);
        checkOutput("two_count", count, 2);
        checkAll("mkbrk");
        popOne();
        checkOutput("brk_1c", ev_data, 16'h801C);
        popOne();
        checkAll("drained");
        popOne();
        checkAll("empty_pop");

        // Shift tagging
        applyStimulus(8'h12, 0, 11, 0, 0);
        applyStimulus(8'h1C, 0, 11, 0, 0);
        applyStimulus(8'hF0, 0, 11, 0, 0);
        applyStimulus(8'h12, 0, 11, 0, 0);
        checkAll("shift_seq");
        checkOutput("shift_head", ev_data, 16'h0412);
        popOne();
        checkOutput("shift_1c", ev_data, 16'h041C);
        popOne();
        checkOutput("shift_brk", ev_data, 16'h8012);
        checkOutput("shift_end", shift, 0);
        popOne();

        // Right ctrl through the extended prefixes
        applyStimulus(8'hE0, 0, 11, 0, 0);
        applyStimulus(8'h14, 0, 11, 0, 0);
        checkOutput("rctrl_on", ctrl, 1);
        checkOutput("rctrl_make", ev_data, 16'h4814);
        popOne();
        applyStimulus(8'hE0, 0, 11, 0, 0);
        applyStimulus(8'hF0, 0, 11, 0, 0);
        applyStimulus(8'h14, 0, 11, 0, 0);
        checkOutput("rctrl_off", ctrl, 0);
        checkOutput("rctrl_brk", ev_data, 16'hC014);
        checkAll("rctrl");
        popOne();

        // Caps lock with typematic repeat
        applyStimulus(8'h58, 0, 11, 0, 0);
        checkOutput("caps_1", caps, 1);
        applyStimulus(8'h58, 0, 11, 0, 0);
        checkOutput("caps_2", caps, 1);
        applyStimulus(8'hF0, 0, 11, 0, 0);
        applyStimulus(8'h58, 0, 11, 0, 0);
        checkOutput("caps_3", caps, 1);
        applyStimulus(8'h58, 0, 11, 0, 0);
        checkOutput("caps_4", caps, 0);
        checkAll("caps");
        repeat (4) popOne();

        // Receive errors
        applyStimulus(8'h1C, 1, 11, 0, 0);
        checkOutput("par_ferr", frame_err, 1);
        checkAll("parity");
        clearErr();
        checkOutput("clr_ferr", frame_err, 0);
        applyStimulus(8'h1C, 0, 5, 0, 0);
        checkOutput("tmo_ferr", frame_err, 1);
        applyStimulus(8'h2B, 0, 11, 0, 0);
        checkAll("after_tmo");
        checkOutput("after_tmo_ev", ev_data, 16'h002B);
        popOne();
        clearErr();

        // Overflow, then full with a pop on the push cycle
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(8'h1C, 0, 11, 0, 0);
        checkOutput("full_count", count, DEPTH);
        checkOutput("full_ovf", ovf, 1);
        checkAll("overflow");
        clearErr();
        applyStimulus(8'h1C, 0, 11, 1, 0);
        checkOutput("pushpop_ovf", ovf, 0);
        checkOutput("pushpop_count", count, DEPTH);
        checkAll("pushpop");
        repeat (DEPTH) popOne();

        // Reset mid-prefix
        applyStimulus(8'hF0, 0, 11, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", ev_valid, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_ferr", frame_err, 0);
        rst = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        applyStimulus(8'h1C, 0, 11, 0, 0);
        checkOutput("rst_make", ev_data, 16'h001C);
        checkAll("post_rst");

        // Randomised traffic
        for (int n = 0; n < 40; n++) begin
            b = pool[$urandom_range(0, 9)];
            if (b == 8'h23) b = 8'($urandom_range(0, 255));
            applyStimulus(b, ($urandom_range(0, 7) == 0), 11, 0, 0);
            if ($urandom_range(0, 2) == 0) popOne();
            if ($urandom_range(0, 9) == 0) clearErr();
            checkAll("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
